// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit CPU subsystem: word/address widths,
// instruction-image loader state encoding and header-byte validity mask.
package cpu10_pkg;

  localparam int AW = 10;
  localparam int DW = 10;

  // Bits that must be zero in any byte that carries only the top two bits of a 10-bit value.
  localparam logic [7:0] HDR_MASK = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_W_HI,
    ST_W_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic is_rx(input state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_W_HI) ||
           (s == ST_W_LO) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a framed, XOR-checksummed byte stream into the external instruction RAM
// while holding the CPU in reset; one write one cycle after each word's low byte.
module imem_loader
  import cpu10_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        r_state;
  state_t        w_next;
  logic [7:0]    r_csum;
  logic [AW-1:0] r_cnt;
  logic [1:0]    r_hi;
  logic [TW-1:0] r_tmo;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic w_rx;
  logic w_acc;
  logic w_start;
  logic w_bad_hi;
  logic w_tmo_hit;
  logic w_wr;

  assign w_rx      = is_rx(r_state);
  assign w_acc     = in_valid && w_rx;
  assign w_start   = start && !w_rx;
  assign w_bad_hi  = |(in_data & HDR_MASK);
  assign w_tmo_hit = w_rx && !w_acc && (r_tmo == TW'(TIMEOUT - 1));
  assign w_wr      = w_acc && (r_state == ST_W_LO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = w_rx;
    cpu_hold = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_HDR_HI;
      ST_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) w_next = ST_HDR_HI;
      end
      ST_ERR: begin
        err = 1'b1;
        if (start) w_next = ST_HDR_HI;
      end
      ST_HDR_HI: if (w_acc) w_next = w_bad_hi ? ST_ERR : ST_HDR_LO;
      ST_HDR_LO: if (w_acc) w_next = ST_W_HI;
      ST_W_HI:   if (w_acc) w_next = w_bad_hi ? ST_ERR : ST_W_LO;
      // r_addr already points at the word being accepted here.
      ST_W_LO:   if (w_acc) w_next = (r_addr == r_cnt) ? ST_CHK : ST_W_HI;
      ST_CHK:    if (w_acc) w_next = (in_data == r_csum) ? ST_DONE : ST_ERR;
      default:   w_next = ST_IDLE;
    endcase
    if (w_tmo_hit) w_next = ST_ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum  <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_tmo   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_wr;
      if (w_start) begin
        r_csum <= '0;
        r_addr <= '0;
        r_tmo  <= '0;
      end else begin
        if (w_acc && (r_state != ST_CHK)) r_csum <= r_csum ^ in_data;
        // Advance after the write cycle, but park on the last address instead of wrapping.
        if (r_we && (r_addr != r_cnt)) r_addr <= r_addr + AW'(1);
        if (w_acc || !w_rx)   r_tmo <= '0;
        else if (!w_tmo_hit)  r_tmo <= r_tmo + TW'(1);
      end
      if (w_acc && (r_state == ST_HDR_HI)) r_cnt[AW-1:8] <= in_data[1:0];
      if (w_acc && (r_state == ST_HDR_LO)) r_cnt[7:0]    <= in_data;
      if (w_acc && (r_state == ST_W_HI))   r_hi          <= in_data[1:0];
      if (w_wr)                            r_wdata       <= {r_hi, in_data};
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       imem_we;
  logic [9:0] imem_addr;
  logic [9:0] imem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [19:0] got[$];

  always #5 clk = ~clk;

  imem_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always @(negedge clk) if (imem_we === 1'b1) got.push_back({imem_addr, imem_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: parse the stream by its framing rules, list the writes and whether it verifies.
  task automatic model(input logic [7:0] b[$], output logic [19:0] w[$], output bit ok);
    int cnt;
    logic [7:0] cs;
    w = {};
    ok = 1'b0;
    if ((b[0] & 8'hFC) != 8'h00) return;
    cnt = int'({b[0][1:0], b[1]});
    cs = b[0] ^ b[1];
    for (int k = 0; k <= cnt; k++) begin
      if (b[2+2*k][7:2] != 6'd0) return;
      w.push_back({10'(k), b[2+2*k][1:0], b[3+2*k]});
      cs = cs ^ b[2+2*k] ^ b[3+2*k];
    end
    ok = (b[4+2*cnt] == cs);
  endtask

  task automatic build(input logic [9:0] words[$], output logic [7:0] b[$]);
    logic [9:0] c;
    logic [7:0] cs;
    c = 10'(words.size() - 1);
    b = {};
    b.push_back({6'd0, c[9:8]});
    b.push_back(c[7:0]);
    foreach (words[i]) begin
      b.push_back({6'd0, words[i][9:8]});
      b.push_back(words[i][7:0]);
    end
    cs = 8'h00;
    foreach (b[i]) cs = cs ^ b[i];
    b.push_back(cs);
  endtask

  task automatic do_start();
    got = {};
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h00;
    chk("start_rdy", {31'd0, in_ready}, 0);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    chk("start_hold", {31'd0, cpu_hold}, 1);
    chk("start_rx", {31'd0, in_ready}, 1);
  endtask

  // Drives bytes at negedges; stops early once the loader reports an error.
  task automatic send(input logic [7:0] b[$], input int gmax, input int start_at,
                      input int long_at, input int long_len);
    int g;
    int w;
    for (int i = 0; i < b.size(); i++) begin
      in_valid = 1'b0;
      g = (i == long_at) ? long_len : int'($urandom_range(gmax, 0));
      repeat (g) @(negedge clk);
      in_valid = 1'b1;
      in_data = b[i];
      start = (i == start_at);
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
        if (err === 1'b1) begin
          in_valid = 1'b0;
          start = 1'b0;
          return;
        end
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        chk("rdy_wait", {31'd0, in_ready}, 1);
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      start = 1'b0;
      if (i >= 3 && (i % 2) == 1 && i < b.size() - 1) begin
        chk("we_pulse", {31'd0, imem_we}, 1);
        chk("we_addr", {22'd0, imem_addr}, (i - 3) / 2);
        chk("we_data", {22'd0, imem_wdata}, {22'd0, b[i-1][1:0], b[i]});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic cmp_writes(input string tag, input logic [19:0] exp[$]);
    chk({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk({tag, "_w"}, {12'd0, got[i]}, {12'd0, exp[i]});
  endtask

  initial begin
    logic [7:0]  s1[$];
    logic [7:0]  s2[$];
    logic [7:0]  s3[$];
    logic [7:0]  sh[$];
    logic [7:0]  sr[$];
    logic [9:0]  wq[$];
    logic [19:0] ew[$];
    bit          ok;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_hold", {31'd0, cpu_hold}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_rdy", {31'd0, in_ready}, 0);
    chk("rst_we", {31'd0, imem_we}, 0);
    chk("rst_addr", {22'd0, imem_addr}, 0);
    chk("rst_wdata", {22'd0, imem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal three-word load.
    s1 = {8'h00, 8'h02, 8'h00, 8'hE1, 8'h01, 8'h05, 8'h00, 8'hFF, 8'h18};
    model(s1, ew, ok);
    chk("t1_model_ok", {31'd0, ok}, 1);
    do_start();
    send(s1, 2, -1, -1, 0);
    chk("t1_done", {31'd0, done}, 1);
    chk("t1_hold", {31'd0, cpu_hold}, 0);
    chk("t1_err", {31'd0, err}, 0);
    cmp_writes("t1", ew);

    // Corrupted checksum, then a clean reload with a stray start mid-stream.
    s2 = s1;
    s2[8] = s1[8] ^ 8'hFF;
    model(s2, ew, ok);
    do_start();
    send(s2, 2, -1, -1, 0);
    chk("t2_err", {31'd0, err}, {31'd0, !ok});
    chk("t2_hold", {31'd0, cpu_hold}, 1);
    chk("t2_done", {31'd0, done}, 0);
    cmp_writes("t2", ew);
    model(s1, ew, ok);
    do_start();
    send(s1, 1, 4, -1, 0);
    chk("t2b_done", {31'd0, done}, 1);
    cmp_writes("t2b", ew);

    // Illegal hi byte on the second word.
    s3 = {8'h00, 8'h02, 8'h00, 8'hE1, 8'h04, 8'h05, 8'h00, 8'hFF, 8'h18};
    model(s3, ew, ok);
    do_start();
    send(s3, 1, -1, -1, 0);
    @(negedge clk);
    chk("t3_err", {31'd0, err}, 1);
    chk("t3_hold", {31'd0, cpu_hold}, 1);
    cmp_writes("t3", ew);

    // Timeout: exactly TMO idle cycles aborts, TMO-1 does not.
    sh = {8'h00, 8'h02};
    do_start();
    send(sh, 0, -1, -1, 0);
    repeat (TMO - 1) @(negedge clk);
    chk("t4_err_early", {31'd0, err}, 0);
    @(negedge clk);
    chk("t4_err", {31'd0, err}, 1);
    chk("t4_rdy", {31'd0, in_ready}, 0);
    chk("t4_n", got.size(), 0);
    model(s1, ew, ok);
    do_start();
    send(s1, 0, -1, 2, TMO - 1);
    chk("t4b_done", {31'd0, done}, 1);
    cmp_writes("t4b", ew);

    // Full 1024-word image with random source gaps.
    wq = {};
    for (int i = 0; i < 1024; i++) wq.push_back(10'($urandom_range(1023, 0)));
    build(wq, sr);
    model(sr, ew, ok);
    do_start();
    send(sr, 3, -1, -1, 0);
    chk("t5_done", {31'd0, done}, {31'd0, ok});
    chk("t5_last_addr", {22'd0, imem_addr}, 1023);
    cmp_writes("t5", ew);

    // Reset after the second word's hi byte aborts the load.
    sh = {8'h00, 8'h02, 8'h00, 8'hE1, 8'h01};
    do_start();
    send(sh, 1, -1, -1, 0);
    rst = 1'b1;
    #1;
    chk("t6_we", {31'd0, imem_we}, 0);
    chk("t6_hold", {31'd0, cpu_hold}, 1);
    chk("t6_rdy", {31'd0, in_ready}, 0);
    chk("t6_err", {31'd0, err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_n", got.size(), 1);
    model(s1, ew, ok);
    do_start();
    send(s1, 2, -1, -1, 0);
    chk("t6b_done", {31'd0, done}, 1);
    chk("t6b_hold", {31'd0, cpu_hold}, 0);
    cmp_writes("t6b", ew);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: TIMEOUT, default 1000, idle cycles allowed between accepted bytes before abort.
REQ-002 Port: clk  in  1  system clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
REQ-005 Port: in_valid  in  1  byte-stream source has a byte.
REQ-006 Port: in_data  in  8  stream byte.
REQ-007 Port: in_ready  out  1  loader accepts a byte this cycle.
REQ-008 Port: imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: imem_addr  out  10  instruction-memory word address.
REQ-010 Port: imem_wdata  out  10  instruction word to write.
REQ-011 Port: cpu_hold  out  1  high holds the 10-bit CPU in reset; drives the CPU rst.
REQ-012 Port: done  out  1  load completed and verified.
REQ-013 Port: err  out  1  load aborted.

Function
REQ-014 A byte SHALL transfer only on a cycle with in_valid && in_ready; in_ready SHALL be high only in HDR_HI, HDR_LO, W_HI, W_LO and CHK, and SHALL not depend combinationally on in_valid.
REQ-015 The stream format SHALL be: HDR_HI (bits[1:0] = cnt[9:8]), HDR_LO (cnt[7:0]), then cnt+1 word pairs (hi byte bits[1:0] = word[9:8], lo byte = word[7:0]), then one checksum byte.
REQ-016 The word count SHALL be cnt+1, range 1..1024; cnt = 1023 fills the whole 10-bit address space.
REQ-017 States SHALL be IDLE, HDR_HI, HDR_LO, W_HI, W_LO, CHK, DONE, ERR.
REQ-018 Transitions SHALL be: IDLE/DONE/ERR -start-> HDR_HI; HDR_HI -> HDR_LO -> W_HI -> W_LO on each accepted byte; W_LO -> W_HI, or -> CHK when the word written is at address cnt; CHK -> DONE on checksum match, else ERR.
REQ-019 A HDR_HI byte or a word hi byte with bits[7:2] non-zero SHALL move to ERR.
REQ-020 On acceptance of a W_LO byte, imem_we SHALL pulse high exactly one cycle later, with imem_addr and imem_wdata registered and stable for that cycle.
REQ-021 imem_addr SHALL start at 0 for every load and increment by 1 after each write; it SHALL never wrap within a load.
REQ-022 The checksum SHALL be the 8-bit XOR of all bytes from HDR_HI through the last word lo byte; the CHK byte SHALL equal it.
REQ-023 The timeout counter SHALL clear on every accepted byte and on start; reaching TIMEOUT cycles in a receiving state SHALL move to ERR.
REQ-024 cpu_hold SHALL be high in every state except DONE; done SHALL be high only in DONE; err SHALL be high only in ERR.
REQ-025 start SHALL be ignored while in a receiving state.
REQ-026 A start while in DONE SHALL reassert cpu_hold on the next cycle.
REQ-027 Entering ERR mid-load SHALL suppress all further imem_we pulses; words already written SHALL remain written.
REQ-028 If start and in_valid coincide in IDLE, the byte SHALL not be accepted that cycle.

Reset
REQ-029 On rst: state IDLE, cpu_hold=1, done=0, err=0, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, checksum=0, timeout counter=0.
REQ-030 rst asserted mid-load SHALL abort immediately, with no imem_we pulse after assertion.

Structure
REQ-031 The state encoding, the header-byte mask (8'hFC), and the address/data widths (10) SHALL live in the shared package cpu10_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the instruction RAM it writes is external.

Verification
REQ-033 Reset, start, then stream 00,02,00,E1,01,05,00,FF,cs: exactly 3 writes (addr 0=0x0E1, 1=0x105, 2=0x0FF), DONE, cpu_hold=0, done=1.
REQ-034 Same stream with checksum byte flipped: 3 writes occur, then ERR with err=1 and cpu_hold=1; a new start followed by a correct stream reaches DONE.
REQ-035 Word hi byte 0x04 as the second word: ERR, only 1 write (addr 0).
REQ-036 in_valid dropped for TIMEOUT cycles after HDR_LO: ERR after exactly TIMEOUT idle cycles; with TIMEOUT-1 idle cycles the load completes.
REQ-037 cnt=0x3FF with random in_valid gaps: 1024 writes at addresses 0..1023 in order, last address 1023, then DONE.
REQ-038 rst pulsed after the second word's hi byte: no further imem_we, state IDLE, cpu_hold=1; start plus full stream then reaches DONE.
